// File: rtl/core_pkg.sv
// Shared core definitions: datapath width, reset vector, NOP encoding and
// the fetch FSM state type.
package core_pkg;

    localparam int unsigned XLEN      = 32;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        BOOT,
        FETCH,
        HALTED
    } fetch_state_e;

endpackage

// File: rtl/fetch_queue.sv
// Two-entry instruction/PC FIFO with flush. The head entry is always slot 0,
// so the head outputs come straight from flops.
module fetch_queue
    import core_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush_i,
    input  logic            push_i,
    input  logic [31:0]     push_instr_i,
    input  logic [XLEN-1:0] push_pc_i,
    input  logic            pop_i,
    output logic            head_valid_o,
    output logic [31:0]     head_instr_o,
    output logic [XLEN-1:0] head_pc_o,
    output logic [1:0]      count_o
);

    logic [31:0]     instr_q [2];
    logic [31:0]     instr_d [2];
    logic [XLEN-1:0] pc_q    [2];
    logic [XLEN-1:0] pc_d    [2];
    logic [1:0]      count_q;
    logic [1:0]      count_d;

    always_comb begin
        instr_d = instr_q;
        pc_d    = pc_q;
        count_d = count_q;
        if (flush_i) begin
            count_d = '0;
        end else begin
            unique case (count_q)
                2'd0: begin
                    if (push_i) begin
                        instr_d[0] = push_instr_i;
                        pc_d[0]    = push_pc_i;
                        count_d    = 2'd1;
                    end
                end
                2'd1: begin
                    if (push_i && pop_i) begin
                        instr_d[0] = push_instr_i;
                        pc_d[0]    = push_pc_i;
                    end else if (push_i) begin
                        instr_d[1] = push_instr_i;
                        pc_d[1]    = push_pc_i;
                        count_d    = 2'd2;
                    end else if (pop_i) begin
                        count_d = 2'd0;
                    end
                end
                2'd2: begin
                    // A push into a full queue is only legal alongside a pop.
                    if (pop_i) begin
                        instr_d[0] = instr_q[1];
                        pc_d[0]    = pc_q[1];
                        if (push_i) begin
                            instr_d[1] = push_instr_i;
                            pc_d[1]    = push_pc_i;
                        end else begin
                            count_d = 2'd1;
                        end
                    end
                end
                default: count_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 2; i++) begin
                instr_q[i] <= '0;
                pc_q[i]    <= '0;
            end
            count_q <= '0;
        end else begin
            instr_q <= instr_d;
            pc_q    <= pc_d;
            count_q <= count_d;
        end
    end

    assign head_valid_o = (count_q != 2'd0);
    assign head_instr_o = instr_q[0];
    assign head_pc_o    = pc_q[0];
    assign count_o      = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues single-cycle word reads and
// hands instructions to decode through a 2-entry queue.
module fetch_unit #(
    parameter int unsigned     XLEN     = core_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = core_pkg::RESET_PC,
    parameter int unsigned     QDEPTH   = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic [31:0]     imem_rdata_i,
    output logic            if_valid_o,
    output logic [31:0]     if_instr_o,
    output logic [XLEN-1:0] if_pc_o,
    input  logic            id_ready_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    input  logic            halt_i,
    output logic            misaligned_o,
    output logic            halted_o
);

    import core_pkg::*;

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            infl_q, infl_d;
    logic [XLEN-1:0] infl_pc_q, infl_pc_d;
    logic            infl_epoch_q, infl_epoch_d;
    logic            epoch_q, epoch_d;
    logic            mis_q, mis_d;

    logic            req;
    logic [2:0]      occ_after;
    logic            q_valid;
    logic            q_push;
    logic            q_pop;
    logic            q_flush;
    logic [1:0]      q_count;

    assign q_pop   = q_valid && id_ready_i;
    assign q_flush = redirect_i;
    // Responses tagged with a stale epoch belong to a redirected-away path.
    assign q_push  = infl_q && (infl_epoch_q == epoch_q);

    fetch_queue #(
        .XLEN(XLEN)
    ) u_queue (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush_i      (q_flush),
        .push_i       (q_push),
        .push_instr_i (imem_rdata_i),
        .push_pc_i    (infl_pc_q),
        .pop_i        (q_pop),
        .head_valid_o (q_valid),
        .head_instr_o (if_instr_o),
        .head_pc_o    (if_pc_o),
        .count_o      (q_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            BOOT:    state_d = halt_i ? HALTED : FETCH;
            FETCH:   state_d = halt_i ? HALTED : FETCH;
            HALTED:  state_d = HALTED;
            default: state_d = BOOT;
        endcase
    end

    always_comb begin
        occ_after = {1'b0, q_count} - {2'b00, q_pop} + {2'b00, infl_q};
        req       = (state_q == FETCH) && (occ_after < 3'(QDEPTH));
    end

    always_comb begin
        pc_d         = pc_q;
        infl_d       = req;
        infl_pc_d    = pc_q;
        infl_epoch_d = epoch_q;
        epoch_d      = epoch_q;
        mis_d        = 1'b0;
        if (redirect_i) begin
            // A request issued this cycle still used the old pc; the epoch
            // flip drops its response.
            pc_d    = {redirect_pc_i[XLEN-1:2], 2'b00};
            epoch_d = ~epoch_q;
            mis_d   = |redirect_pc_i[1:0];
        end else if (req) begin
            pc_d = pc_q + XLEN'(4);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q         <= RESET_PC;
            infl_q       <= 1'b0;
            infl_pc_q    <= '0;
            infl_epoch_q <= 1'b0;
            epoch_q      <= 1'b0;
            mis_q        <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            infl_q       <= infl_d;
            infl_pc_q    <= infl_pc_d;
            infl_epoch_q <= infl_epoch_d;
            epoch_q      <= epoch_d;
            mis_q        <= mis_d;
        end
    end

    assign imem_req_o   = req;
    assign imem_addr_o  = req ? pc_q : '0;
    assign if_valid_o   = q_valid;
    assign misaligned_o = mis_q;
    assign halted_o     = (state_q == HALTED);

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit against a queue-based reference model of
// the fetch stream, plus directed checks of the key scenarios.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic [31:0] imem_rdata_i = '0;
    logic        if_valid_o;
    logic [31:0] if_instr_o;
    logic [31:0] if_pc_o;
    logic        id_ready_i = 1'b0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic        halt_i = 1'b0;
    logic        misaligned_o;
    logic        halted_o;

    fetch_unit #(
        .XLEN     (32),
        .RESET_PC (32'h0000_0000),
        .QDEPTH   (2)
    ) u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_rdata_i  (imem_rdata_i),
        .if_valid_o    (if_valid_o),
        .if_instr_o    (if_instr_o),
        .if_pc_o       (if_pc_o),
        .id_ready_i    (id_ready_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .halt_i        (halt_i),
        .misaligned_o  (misaligned_o),
        .halted_o      (halted_o)
    );

    always #5 clk = ~clk;

    logic overflow;
    assign overflow = (u_dut.q_count == 2'd2) && u_dut.q_push && !u_dut.q_pop && !u_dut.q_flush;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0000_0013;
        if (a == 32'h4) return 32'h0010_0093;
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } ent_t;

    // Reference model: m_state 0 = boot, 1 = fetching, 2 = halted.
    ent_t        mq[$];
    int          m_state;
    bit          m_infl, m_kill, m_mis;
    logic [31:0] m_infl_pc, m_pc;
    logic [31:0] got_pcs[$];
    bit          pend_req;
    logic [31:0] pend_addr;
    logic        s_valid, s_req, s_mis, s_halted;
    logic [31:0] s_addr, s_pc;

    function automatic logic [31:0] got_at(input int i);
        return (got_pcs.size() > i) ? got_pcs[i] : 32'hDEAD_BEEF;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_state = 0; m_infl = 0; m_kill = 0; m_mis = 0;
        m_infl_pc = '0; m_pc = 32'h0;
        pend_req = 0; pend_addr = '0;
    endtask

    task automatic step();
        bit pop, exp_req;
        @(negedge clk);
        s_valid = if_valid_o; s_req = imem_req_o; s_addr = imem_addr_o;
        s_pc = if_pc_o; s_mis = misaligned_o; s_halted = halted_o;
        pop     = (mq.size() > 0) && id_ready_i;
        exp_req = (m_state == 1) && (mq.size() - int'(pop) + int'(m_infl) < 2);
        check("if_valid", if_valid_o, mq.size() > 0);
        if (mq.size() > 0) begin
            check("if_instr", if_instr_o, mq[0].instr);
            check("if_pc", if_pc_o, mq[0].pc);
        end
        check("imem_req", imem_req_o, exp_req);
        check("imem_addr", imem_addr_o, exp_req ? m_pc : 32'h0);
        check("halted", halted_o, m_state == 2);
        check("misaligned", misaligned_o, m_mis);
        check("q_overflow", overflow, 1'b0);
        if (if_valid_o && id_ready_i) got_pcs.push_back(if_pc_o);
        if (pop) void'(mq.pop_front());
        if (redirect_i) mq.delete();
        else if (m_infl && !m_kill) mq.push_back('{mem_word(m_infl_pc), m_infl_pc});
        m_kill    = redirect_i;
        m_infl    = exp_req;
        m_infl_pc = m_pc;
        m_mis     = redirect_i && (redirect_pc_i[1:0] != 2'b00);
        if (redirect_i) m_pc = {redirect_pc_i[31:2], 2'b00};
        else if (exp_req) m_pc = m_pc + 32'd4;
        if (m_state != 2 && halt_i) m_state = 2;
        else if (m_state == 0) m_state = 1;
        pend_req  = imem_req_o;
        pend_addr = imem_addr_o;
        @(posedge clk);
        #1;
        imem_rdata_i = pend_req ? mem_word(pend_addr) : $urandom();
        redirect_i = 1'b0;
        halt_i     = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_valid", if_valid_o, 1'b0);
        check("rst_req", imem_req_o, 1'b0);
        check("rst_addr", imem_addr_o, 32'h0);
        check("rst_instr", if_instr_o, 32'h0);
        check("rst_pc", if_pc_o, 32'h0);
        check("rst_halted", halted_o, 1'b0);
        check("rst_mis", misaligned_o, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        model_reset();
        redirect_i = 1'b0;
        halt_i = 1'b0;
        imem_rdata_i = $urandom();
        rst_n = 1'b1;
    endtask

    task automatic wait_first_valid(input logic [31:0] exp_pc);
        int lat;
        lat = -1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (s_valid) begin
                lat = i;
                break;
            end
        end
        check("first_valid_latency", lat, 3);
        check("first_pc", s_pc, exp_pc);
    endtask

    initial begin
        model_reset();

        // Streaming from reset.
        id_ready_i = 1'b1;
        do_reset();
        got_pcs.delete();
        wait_first_valid(32'h0);
        step(); step();
        check("stream_count", got_pcs.size(), 3);
        check("stream_pc0", got_at(0), 32'h0);
        check("stream_pc1", got_at(1), 32'h4);
        check("stream_pc2", got_at(2), 32'h8);

        // Back-pressure: queue fills, requests stop, order preserved.
        do_reset();
        id_ready_i = 1'b0;
        wait_first_valid(32'h0);
        repeat (5) step();
        check("stall_req", s_req, 1'b0);
        check("stall_valid", s_valid, 1'b1);
        check("stall_head", s_pc, 32'h0);
        got_pcs.delete();
        id_ready_i = 1'b1;
        repeat (3) step();
        check("resume_pc0", got_at(0), 32'h0);
        check("resume_pc1", got_at(1), 32'h4);
        check("resume_pc2", got_at(2), 32'h8);

        // Redirect with full queue and a request issued in the same cycle.
        id_ready_i = 1'b0;
        repeat (3) step();
        id_ready_i = 1'b1;
        redirect_i = 1'b1;
        redirect_pc_i = 32'h100;
        step();
        check("redir_old_req", s_req, 1'b1);
        got_pcs.delete();
        step();
        check("redir_valid_drop", s_valid, 1'b0);
        check("redir_req", s_req, 1'b1);
        check("redir_addr", s_addr, 32'h100);
        repeat (3) step();
        check("redir_first_pc", got_at(0), 32'h100);

        // Misaligned redirect target.
        redirect_i = 1'b1;
        redirect_pc_i = 32'h102;
        step();
        got_pcs.delete();
        step();
        check("mis_pulse", s_mis, 1'b1);
        step();
        check("mis_clear", s_mis, 1'b0);
        repeat (2) step();
        check("mis_first_pc", got_at(0), 32'h100);

        // PC wrap-around.
        redirect_i = 1'b1;
        redirect_pc_i = 32'hFFFF_FFF8;
        step();
        got_pcs.delete();
        repeat (5) step();
        check("wrap_pc0", got_at(0), 32'hFFFF_FFF8);
        check("wrap_pc1", got_at(1), 32'hFFFF_FFFC);
        check("wrap_pc2", got_at(2), 32'h0);

        // Random traffic.
        for (int i = 0; i < 300; i++) begin
            id_ready_i = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) begin
                redirect_i = 1'b1;
                redirect_pc_i = $urandom() & 32'h0000_0FFF;
            end
            step();
        end

        // Halt with a full queue; queued entries still drain.
        id_ready_i = 1'b0;
        repeat (5) step();
        halt_i = 1'b1;
        step();
        step();
        check("halt_req", s_req, 1'b0);
        check("halt_flag", s_halted, 1'b1);
        got_pcs.delete();
        id_ready_i = 1'b1;
        repeat (4) step();
        check("halt_drained", got_pcs.size(), 2);
        check("halt_empty", s_valid, 1'b0);
        redirect_i = 1'b1;
        redirect_pc_i = 32'h40;
        step();
        step();
        check("halt_redir_flag", s_halted, 1'b1);
        check("halt_redir_req", s_req, 1'b0);
        repeat (8) step();

        // Reset while a request is in flight.
        do_reset();
        id_ready_i = 1'b1;
        repeat (8) step();
        check("pre_reset_req", s_req, 1'b1);
        do_reset();
        wait_first_valid(32'h0);
        repeat (5) step();

        // Halt during BOOT.
        do_reset();
        halt_i = 1'b1;
        step();
        repeat (2) step();
        check("boot_halt_flag", s_halted, 1'b1);
        check("boot_halt_req", s_req, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
